alu_reg_stage: RTL and testbench
================================

ALU_REG_STAGE -- requirements
Module: alu_reg_stage

Interface
REQ-001 Parameter WIDTH, default 32: width of the enabled data register (d_i/q_o); the ALU datapath is fixed at 32 bits.
REQ-002 Parameter RESET_VAL, default 0: value loaded into both registers on reset.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-low.
REQ-005 a_i32  input  32  ALU operand A.
REQ-006 b_i32  input  32  ALU operand B.
REQ-007 funct_i6  input  6  R-type function field, used only when alt_ctrl_i2 = 2'b10.
REQ-008 alt_ctrl_i2  input  2  ALU operation class select.
REQ-009 en_i  input  1  write enable for the enabled register.
REQ-010 d_i  input  WIDTH  data into the enabled register.
REQ-011 y_o32  output  32  combinational ALU result.
REQ-012 zero_o  output  1  combinational flag, 1 when y_o32 = 0.
REQ-013 alu_out_o32  output  32  y_o32 registered every cycle (ALUOut).
REQ-014 q_o  output  WIDTH  enabled register output.

Function
REQ-015 alt_ctrl_i2 = 00 SHALL give y = A + B, 01 SHALL give y = A - B, 11 SHALL give y = A + B, and 10 SHALL decode funct_i6 as listed in REQ-016.
REQ-016 funct_i6 decode SHALL be:
- 100000 and 100001: add.
- 100010 and 100011: sub.
- 100100: and.
- 100101: or.
- 100110: xor.
- 100111: nor.
- 101010: slt, signed, result 32'd1 or 32'd0.
- 101011: sltu, unsigned, result 32'd1 or 32'd0.
- Any other code: y = 0.
REQ-017 Add and sub SHALL wrap modulo 2^32, with no overflow or carry output or trap.
REQ-018 y_o32 and zero_o SHALL be purely combinational, settling in the same cycle the inputs change, and SHALL be unaffected by clk_i and reset_i.
REQ-019 alu_out_o32 SHALL take the value of y_o32 at each rising edge, giving 1-cycle latency with no enable.
REQ-020 q_o SHALL load d_i at a rising edge when en_i = 1 and SHALL hold its value when en_i = 0.
REQ-021 When reset is asserted in the same cycle as en_i = 1, reset SHALL take priority.

Reset
REQ-022 At a rising edge with reset_i = 0, alu_out_o32 and q_o SHALL both become RESET_VAL, regardless of en_i or the ALU inputs.
REQ-023 Reset SHALL be synchronous only; asserting reset_i between clock edges SHALL not change any register.
REQ-024 Combinational outputs SHALL continue to reflect the current inputs while reset is asserted.
REQ-025 The first load after reset deasserts SHALL occur at the first rising edge with reset_i = 1.

Structure
REQ-026 alt_ctrl_i2 encodings and funct_i6 codes SHALL be localparams in a shared package, alu_pkg, together with the instruction opcodes used by the control unit.
REQ-027 The enable and plain registers SHALL be one reusable sub-module, flopenr, parameterized by WIDTH and RESET_VAL; the plain register SHALL be that sub-module with its enable tied to 1.
REQ-028 The ALU SHALL be one combinational always block using a case statement and a default branch, so that no latches are inferred.

Verification
REQ-029 A=5, B=3, alt=00 -> y=8, zero=0; on the next edge alu_out=8.
REQ-030 A=7, B=7, alt=01 -> y=0, zero=1.
REQ-031 A=0xFFFFFFFF, B=1, alt=10, funct=101010 (slt) -> y=1; funct=101011 (sltu) -> y=0; funct=100000 (add) -> y=0 (wrap), zero=1.
REQ-032 A=0x0F0F0F0F, B=0x00FF00FF, alt=10 -> and gives 0x000F000F, or gives 0x0FFF0FFF, nor gives 0xF000F000; funct=111111 -> y=0.
REQ-033 d_i=0x1234, en=1, edge -> q=0x1234; then d_i=0x5678 with en=0, edge -> q stays 0x1234.
REQ-034 reset_i=0 with en=1 and d_i=0xAAAA, edge -> q=0 and alu_out=0; reset_i pulsed low mid-cycle and released before the edge -> no change.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation-class encodings, R-type function codes and
// instruction opcodes used by the datapath and the control unit.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    localparam logic [1:0] ALT_ADD     = 2'b00;
    localparam logic [1:0] ALT_SUB     = 2'b01;
    localparam logic [1:0] ALT_RTYPE   = 2'b10;
    localparam logic [1:0] ALT_ADD_ALT = 2'b11;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/alu_reg_stage_if.sv
// Operand, control and result bundle of the ALU/register stage.
interface alu_reg_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic [31:0]      a_i32;
    logic [31:0]      b_i32;
    logic [5:0]       funct_i6;
    logic [1:0]       alt_ctrl_i2;
    logic             en_i;
    logic [WIDTH-1:0] d_i;
    logic [31:0]      y_o32;
    logic             zero_o;
    logic [31:0]      alu_out_o32;
    logic [WIDTH-1:0] q_o;

    modport master (
        output a_i32, b_i32, funct_i6, alt_ctrl_i2, en_i, d_i,
        input  y_o32, zero_o, alu_out_o32, q_o
    );

    modport slave (
        input  a_i32, b_i32, funct_i6, alt_ctrl_i2, en_i, d_i,
        output y_o32, zero_o, alu_out_o32, q_o
    );
endinterface

// File: rtl/flopenr.sv
// Resettable register with write enable; reset is synchronous, active-low
// and wins over the enable.
module flopenr #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/alu_reg_stage.sv
// 32-bit ALU with a free-running result register (ALUOut) and a separate
// enabled data register.
module alu_reg_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    alu_reg_stage_if.slave bus
);
    localparam logic [ALU_W-1:0] ALU_RST = ALU_W'(RESET_VAL);
    localparam logic [WIDTH-1:0] Q_RST   = WIDTH'(RESET_VAL);

    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [ALU_W-1:0] y_d;

    assign a = bus.a_i32;
    assign b = bus.b_i32;

    always_comb begin
        y_d = '0;
        case (bus.alt_ctrl_i2)
            ALT_ADD, ALT_ADD_ALT: y_d = a + b;
            ALT_SUB:              y_d = a - b;
            ALT_RTYPE: begin
                case (bus.funct_i6)
                    F_ADD, F_ADDU: y_d = a + b;
                    F_SUB, F_SUBU: y_d = a - b;
                    F_AND:         y_d = a & b;
                    F_OR:          y_d = a | b;
                    F_XOR:         y_d = a ^ b;
                    F_NOR:         y_d = ~(a | b);
                    F_SLT:         y_d = {31'b0, $signed(a) < $signed(b)};
                    F_SLTU:        y_d = {31'b0, a < b};
                    default:       y_d = '0;
                endcase
            end
            default: y_d = '0;
        endcase
    end

    assign bus.y_o32  = y_d;
    assign bus.zero_o = (y_d == '0);

    // ALUOut is the same register cell with its enable tied high.
    flopenr #(
        .WIDTH     (ALU_W),
        .RESET_VAL (ALU_RST)
    ) u_alu_out (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (1'b1),
        .d_i     (y_d),
        .q_o     (bus.alu_out_o32)
    );

    flopenr #(
        .WIDTH     (WIDTH),
        .RESET_VAL (Q_RST)
    ) u_data_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (bus.en_i),
        .d_i     (bus.d_i),
        .q_o     (bus.q_o)
    );
endmodule

// File: tb/tb_alu_reg_stage.sv
// Directed vectors drive the stage; expected outputs go into a queue that a
// separate monitor drains and compares on each falling edge.
module tb_alu_reg_stage;
    typedef struct {
        string       name;
        logic [31:0] y;
        logic        zero;
        logic [31:0] alu_out;
        logic [31:0] q;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    logic        prev_rst;
    logic        prev_en;
    logic [31:0] prev_d;
    logic [31:0] prev_y;
    logic [31:0] m_alu;
    logic [31:0] m_q;

    alu_reg_stage_if #(.WIDTH(32)) bus ();

    alu_reg_stage #(
        .WIDTH     (32),
        .RESET_VAL (0)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".y"},       bus.y_o32,           e.y);
            check({e.name, ".zero"},    {31'b0, bus.zero_o}, {31'b0, e.zero});
            check({e.name, ".alu_out"}, bus.alu_out_o32,     e.alu_out);
            check({e.name, ".q"},       bus.q_o,             e.q);
        end
    end

    // One cycle: registers advance on the edge from the previous inputs,
    // then new inputs are applied and the outputs expected before the next
    // edge are queued.
    task automatic step(input string name, input logic rst, input logic pulse,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] funct, input logic [1:0] alt,
                        input logic en, input logic [31:0] d, input logic [31:0] y);
        exp_t e;
        @(posedge clk);
        #1;
        if (!prev_rst) begin
            m_alu = '0;
            m_q   = '0;
        end else begin
            m_alu = prev_y;
            if (prev_en) m_q = prev_d;
        end
        rst_n           = rst;
        bus.a_i32       = a;
        bus.b_i32       = b;
        bus.funct_i6    = funct;
        bus.alt_ctrl_i2 = alt;
        bus.en_i        = en;
        bus.d_i         = d;
        e.name    = name;
        e.y       = y;
        e.zero    = (y == 32'h0);
        e.alu_out = m_alu;
        e.q       = m_q;
        sb.push_back(e);
        prev_rst = rst;
        prev_en  = en;
        prev_d   = d;
        prev_y   = y;
        if (pulse) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        prev_rst = 1'b0;
        prev_en  = 1'b0;
        prev_d   = '0;
        prev_y   = '0;
        m_alu    = '0;
        m_q      = '0;
        rst_n           = 1'b0;
        bus.a_i32       = '0;
        bus.b_i32       = '0;
        bus.funct_i6    = '0;
        bus.alt_ctrl_i2 = '0;
        bus.en_i        = 1'b1;
        bus.d_i         = 32'h0000AAAA;

        //    name        rst   pulse a             b             funct      alt    en    d             y
        step("rst_add",   1'b0, 1'b0, 32'd5,        32'd3,        6'b000000, 2'b00, 1'b1, 32'h0000AAAA, 32'd8);
        step("rst_sub0",  1'b0, 1'b0, 32'd7,        32'd7,        6'b000000, 2'b01, 1'b1, 32'h0000AAAA, 32'd0);
        step("load1234",  1'b1, 1'b0, 32'd5,        32'd3,        6'b000000, 2'b00, 1'b1, 32'h00001234, 32'd8);
        step("slt",       1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        6'b101010, 2'b10, 1'b0, 32'h00005678, 32'd1);
        step("sltu",      1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        6'b101011, 2'b10, 1'b0, 32'h00005678, 32'd0);
        step("addwrap",   1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        6'b100000, 2'b10, 1'b0, 32'h00005678, 32'd0);
        step("and",       1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b100100, 2'b10, 1'b0, 32'h0, 32'h000F000F);
        step("or",        1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b100101, 2'b10, 1'b0, 32'h0, 32'h0FFF0FFF);
        step("nor",       1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b100111, 2'b10, 1'b0, 32'h0, 32'hF000F000);
        step("badfunct",  1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b111111, 2'b10, 1'b0, 32'h0, 32'h00000000);
        step("xor",       1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b100110, 2'b10, 1'b0, 32'h0, 32'h0FF00FF0);
        step("rsub",      1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b100010, 2'b10, 1'b0, 32'h0, 32'h0E100E10);
        step("rsubu",     1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b100011, 2'b10, 1'b0, 32'h0, 32'h0E100E10);
        step("raddu",     1'b1, 1'b0, 32'h0F0F0F0F, 32'h00FF00FF, 6'b100001, 2'b10, 1'b0, 32'h0, 32'h100E100E);
        step("alt11add",  1'b1, 1'b0, 32'd5,        32'd3,        6'b100100, 2'b11, 1'b0, 32'h0, 32'd8);
        step("subwrap",   1'b1, 1'b0, 32'd3,        32'd5,        6'b000000, 2'b01, 1'b0, 32'h0, 32'hFFFFFFFE);
        step("slt_neg",   1'b1, 1'b0, 32'd3,        32'hFFFFFFFF, 6'b101010, 2'b10, 1'b0, 32'h0, 32'd0);
        step("sltu_big",  1'b1, 1'b0, 32'd3,        32'hFFFFFFFF, 6'b101011, 2'b10, 1'b0, 32'h0, 32'd1);
        step("nor_zero",  1'b1, 1'b0, 32'd0,        32'd0,        6'b100111, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF);
        step("alt00ign",  1'b1, 1'b0, 32'd5,        32'd3,        6'b111111, 2'b00, 1'b0, 32'h0, 32'd8);
        step("midpulse",  1'b1, 1'b1, 32'd9,        32'd4,        6'b000000, 2'b01, 1'b1, 32'h0000CAFE, 32'd5);
        step("afterpls",  1'b1, 1'b0, 32'd1,        32'd1,        6'b000000, 2'b00, 1'b0, 32'h0000BEEF, 32'd2);
        step("hold",      1'b1, 1'b0, 32'd0,        32'd0,        6'b000000, 2'b00, 1'b0, 32'h0, 32'd0);
        step("rst_again", 1'b0, 1'b0, 32'd2,        32'd2,        6'b000000, 2'b00, 1'b1, 32'h0000AAAA, 32'd4);
        step("postrst",   1'b1, 1'b0, 32'd0,        32'd0,        6'b000000, 2'b00, 1'b0, 32'h0, 32'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
